// File: rtl/biriscv_csr_counters_pkg.sv
// Shared CSR addresses and counter slot indices for the counter/timer CSR bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package biriscv_csr_counters_pkg;

    // Machine counters: low half at base + index, high half at +0x80.
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
    // Read-only user shadows: cycle/time/instret/hpmcounterN.
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    // mcountinhibit; mhpmeventN sits at mcountinhibit + N.
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    // Memory-mapped timer exposed as custom CSRs.
    localparam logic [11:0] CSR_MTIMECMP      = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH     = 12'h7C1;
    localparam logic [11:0] CSR_MTIME         = 12'h7C2;
    localparam logic [11:0] CSR_MTIMEH        = 12'h7C3;

    // Counter slot indices; these double as mcountinhibit bit positions.
    localparam int CNT_CY       = 0;
    localparam int CNT_TM       = 1;
    localparam int CNT_IR       = 2;
    localparam int CNT_HPM_BASE = 3;

endpackage

// File: rtl/biriscv_csr_counter64.sv
// One 64-bit counter with independently writable 32-bit halves and a wrap strobe.
// Latency: write or increment visible the cycle after; wrap_o is combinational with the wrapping increment.
// Backpressure: none; a write to either half suppresses that cycle's increment entirely.
module biriscv_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  inc_i,
    input  logic        inhibit_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o,
    output logic        wrap_o
);

    logic [63:0] r_value;
    logic [64:0] w_sum;
    logic        w_inc_en;

    // A write discards the increment, so the unwritten half never sees a lost carry.
    assign w_inc_en = !inhibit_i && (inc_i != 2'd0) && !wr_lo_i && !wr_hi_i;
    assign w_sum    = {1'b0, r_value} + {63'd0, inc_i};
    assign wrap_o   = w_inc_en && w_sum[64];
    assign value_o  = r_value;

    // Counter state: reset, then half-writes, then increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_value <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) r_value[31:0]  <= wdata_i;
            if (wr_hi_i) r_value[63:32] <= wdata_i;
        end else if (w_inc_en) begin
            r_value <= w_sum[63:0];
        end
    end

endmodule

// File: rtl/biriscv_csr_counters.sv
// Counter/timer CSR bank: mcycle, minstret, HPM counters, mtime/mtimecmp, timer and overflow IRQs.
// Latency: CSR read data one cycle after csr_ren_i; writes visible next cycle; timer_irq_o one cycle after compare.
// Backpressure: none; reads and writes are accepted every cycle. BIRISCV_HPM_OVF_IRQ_EN enables sticky HPM overflow flags.
module biriscv_csr_counters
    import biriscv_csr_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int RETIRE_W   = 2,
    parameter int TIMER_DIV  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_ren_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_rhit_o,
    input  logic [11:0]           csr_waddr_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic [RETIRE_W-1:0]   retire_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  timer_irq_o,
    output logic                  ovf_irq_o
);

    localparam int          NUM_CNT      = CNT_HPM_BASE + NUM_HPM;
    localparam logic [31:0] CNT_IMPL     = 32'((64'd1 << NUM_CNT) - 64'd1);
    localparam logic [31:0] INHIBIT_MASK = CNT_IMPL & ~(32'd1 << CNT_TM);
    localparam int          PW           = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [63:0]   w_cnt [32];
    logic [31:0]   w_wrap;
    logic [4:0]    w_evt_sel [32];
    logic [31:0]   w_of;
    logic [31:0]   w_evt_ext;
    logic [1:0]    w_retire_cnt;
    logic          w_tick;
    logic          w_mtime_wr;
    logic [PW-1:0] r_presc;
    logic [31:0]   r_mcountinhibit;
    logic [63:0]   r_mtimecmp;
    logic [31:0]   w_rdata;
    logic          w_rhit;
    logic [4:0]    w_ridx;
    logic          w_rhalf;
    logic [31:0]   r_rdata;
    logic          r_rhit;
    logic          r_timer_irq;
    logic          w_unused_wrap;

    // Event k selects event_i[k-1]; slot 0 and slots past NUM_EVENTS stay zero.
    always_comb begin
        w_evt_ext               = '0;
        w_evt_ext[NUM_EVENTS:1] = event_i;
    end

    // Retirements this cycle, one bit per issue slot.
    always_comb begin
        w_retire_cnt = '0;
        for (int j = 0; j < RETIRE_W; j++) begin
            w_retire_cnt = w_retire_cnt + {1'b0, retire_i[j]};
        end
    end

    assign w_tick     = (r_presc == PW'(TIMER_DIV - 1));
    assign w_mtime_wr = (csr_waddr_i == CSR_MTIME) || (csr_waddr_i == CSR_MTIMEH);

    // mtime prescaler; a write to mtime restarts the divide period.
    always_ff @(posedge clk_i) begin
        if (rst_i)                    r_presc <= '0;
        else if (w_mtime_wr || w_tick) r_presc <= '0;
        else                          r_presc <= r_presc + 1'b1;
    end

    // mcountinhibit keeps only bits of implemented, inhibitable counters.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                  r_mcountinhibit <= '0;
        else if (csr_waddr_i == CSR_MCOUNTINHIBIT)  r_mcountinhibit <= csr_wdata_i & INHIBIT_MASK;
    end

    // mtimecmp halves, all-ones at reset so the timer IRQ starts quiet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtimecmp <= '1;
        end else begin
            if (csr_waddr_i == CSR_MTIMECMP)  r_mtimecmp[31:0]  <= csr_wdata_i;
            if (csr_waddr_i == CSR_MTIMECMPH) r_mtimecmp[63:32] <= csr_wdata_i;
        end
    end

    // Slot i: 0 mcycle, 1 mtime, 2 minstret, 3.. HPM counters; unused slots read zero.
    for (genvar i = 0; i < 32; i++) begin : g_cnt
        if (i < NUM_CNT) begin : g_impl
            logic [1:0] w_inc;
            logic       w_inh;
            logic       w_wr_lo;
            logic       w_wr_hi;

            if (i == CNT_TM) begin : g_time
                assign w_inc        = {1'b0, w_tick};
                assign w_inh        = 1'b0;
                assign w_wr_lo      = (csr_waddr_i == CSR_MTIME);
                assign w_wr_hi      = (csr_waddr_i == CSR_MTIMEH);
                assign w_evt_sel[i] = '0;
                assign w_of[i]      = 1'b0;
            end else begin : g_csr
                assign w_inh   = r_mcountinhibit[i];
                assign w_wr_lo = (csr_waddr_i == CSR_MCYCLE + 12'(i));
                assign w_wr_hi = (csr_waddr_i == CSR_MCYCLE + CSR_HI_OFFSET + 12'(i));

                if (i == CNT_CY) begin : g_cy
                    assign w_inc        = 2'd1;
                    assign w_evt_sel[i] = '0;
                    assign w_of[i]      = 1'b0;
                end else if (i == CNT_IR) begin : g_ir
                    assign w_inc        = w_retire_cnt;
                    assign w_evt_sel[i] = '0;
                    assign w_of[i]      = 1'b0;
                end else begin : g_hpm
                    logic [4:0] r_sel;
                    logic       w_evt_wr;

                    assign w_evt_wr     = (csr_waddr_i == CSR_MCOUNTINHIBIT + 12'(i));
                    assign w_inc        = {1'b0, w_evt_ext[r_sel]};
                    assign w_evt_sel[i] = r_sel;

                    // Event selector for this counter.
                    always_ff @(posedge clk_i) begin
                        if (rst_i)         r_sel <= '0;
                        else if (w_evt_wr) r_sel <= csr_wdata_i[4:0];
                    end
`ifdef BIRISCV_HPM_OVF_IRQ_EN
                    logic r_of;
                    // Sticky overflow flag: a wrap wins over a software clear in the same cycle.
                    always_ff @(posedge clk_i) begin
                        if (rst_i)          r_of <= 1'b0;
                        else if (w_wrap[i]) r_of <= 1'b1;
                        else if (w_evt_wr)  r_of <= r_of & csr_wdata_i[31];
                    end
                    assign w_of[i] = r_of;
`else
                    assign w_of[i] = 1'b0;
`endif
                end
            end

            biriscv_csr_counter64 u_cnt (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .inc_i     (w_inc),
                .inhibit_i (w_inh),
                .wr_lo_i   (w_wr_lo),
                .wr_hi_i   (w_wr_hi),
                .wdata_i   (csr_wdata_i),
                .value_o   (w_cnt[i]),
                .wrap_o    (w_wrap[i])
            );
        end else begin : g_none
            assign w_cnt[i]     = '0;
            assign w_wrap[i]    = 1'b0;
            assign w_evt_sel[i] = '0;
            assign w_of[i]      = 1'b0;
        end
    end

    // Wrap strobes only matter to overflow flags; the rest are intentionally dropped.
    assign w_unused_wrap = |w_wrap;

    // Read decode: counter regions by index, then event/inhibit block, then timer registers.
    always_comb begin
        w_rdata = '0;
        w_rhit  = 1'b0;
        w_ridx  = csr_raddr_i[4:0];
        w_rhalf = csr_raddr_i[7];
        if ((csr_raddr_i & 12'hF60) == CSR_MCYCLE) begin
            w_rhit = CNT_IMPL[w_ridx] && (w_ridx != 5'(CNT_TM));
            if (w_rhit) w_rdata = w_rhalf ? w_cnt[w_ridx][63:32] : w_cnt[w_ridx][31:0];
        end else if ((csr_raddr_i & 12'hF60) == CSR_CYCLE) begin
            w_rhit = CNT_IMPL[w_ridx];
            if (w_rhit) w_rdata = w_rhalf ? w_cnt[w_ridx][63:32] : w_cnt[w_ridx][31:0];
        end else if ((csr_raddr_i & 12'hFE0) == CSR_MCOUNTINHIBIT) begin
            if (w_ridx == 5'd0) begin
                w_rhit  = 1'b1;
                w_rdata = r_mcountinhibit;
            end else if ((w_ridx >= 5'(CNT_HPM_BASE)) && CNT_IMPL[w_ridx]) begin
                w_rhit  = 1'b1;
                w_rdata = {w_of[w_ridx], 26'd0, w_evt_sel[w_ridx]};
            end
        end else begin
            case (csr_raddr_i)
                CSR_MTIMECMP:  begin w_rhit = 1'b1; w_rdata = r_mtimecmp[31:0];      end
                CSR_MTIMECMPH: begin w_rhit = 1'b1; w_rdata = r_mtimecmp[63:32];     end
                CSR_MTIME:     begin w_rhit = 1'b1; w_rdata = w_cnt[CNT_TM][31:0];  end
                CSR_MTIMEH:    begin w_rhit = 1'b1; w_rdata = w_cnt[CNT_TM][63:32]; end
                default:       ;
            endcase
        end
    end

    // Registered read port and timer compare; read data returns to zero when not strobed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata     <= '0;
            r_rhit      <= 1'b0;
            r_timer_irq <= 1'b0;
        end else begin
            r_rdata     <= csr_ren_i ? w_rdata : 32'd0;
            r_rhit      <= csr_ren_i && w_rhit;
            r_timer_irq <= (w_cnt[CNT_TM] >= r_mtimecmp);
        end
    end

    assign csr_rdata_o = r_rdata;
    assign csr_rhit_o  = r_rhit;
    assign timer_irq_o = r_timer_irq;

`ifdef BIRISCV_HPM_OVF_IRQ_EN
    logic r_ovf_irq;
    // Overflow interrupt is the registered OR of all sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_ovf_irq <= 1'b0;
        else       r_ovf_irq <= |w_of;
    end
    assign ovf_irq_o = r_ovf_irq;
`else
    assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_biriscv_csr_counters.sv
// Directed bench for the counter/timer CSR bank (NUM_HPM=4, NUM_EVENTS=8, RETIRE_W=2, TIMER_DIV=4).
// Latency: checks read data one cycle after the strobe and the timer IRQ one cycle after the compare.
// Backpressure: n/a.
module tb_biriscv_csr_counters;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        csr_ren_i;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        csr_rhit_o;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic [1:0]  retire_i;
    logic [7:0]  event_i;
    logic        timer_irq_o;
    logic        ovf_irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    biriscv_csr_counters #(
        .NUM_HPM    (4),
        .NUM_EVENTS (8),
        .RETIRE_W   (2),
        .TIMER_DIV  (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .csr_ren_i   (csr_ren_i),
        .csr_raddr_i (csr_raddr_i),
        .csr_rdata_o (csr_rdata_o),
        .csr_rhit_o  (csr_rhit_o),
        .csr_waddr_i (csr_waddr_i),
        .csr_wdata_i (csr_wdata_i),
        .retire_i    (retire_i),
        .event_i     (event_i),
        .timer_irq_o (timer_irq_o),
        .ovf_irq_o   (ovf_irq_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_waddr_i = a;
        csr_wdata_i = d;
        tick(1);
        csr_waddr_i = 12'h000;
        csr_wdata_i = 32'h0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic h);
        csr_ren_i   = 1'b1;
        csr_raddr_i = a;
        tick(1);
        d = csr_rdata_o;
        h = csr_rhit_o;
        csr_ren_i   = 1'b0;
        csr_raddr_i = 12'h000;
    endtask

    task automatic pulse(input logic [7:0] ev, input int n);
        for (int p = 0; p < n; p++) begin
            event_i = ev;
            tick(1);
            event_i = 8'h00;
            tick(1);
        end
    endtask

    initial begin
        logic [31:0] d, d1, d2;
        logic        h;

        rst_i       = 1'b1;
        csr_ren_i   = 1'b0;
        csr_raddr_i = 12'h000;
        csr_waddr_i = 12'h000;
        csr_wdata_i = 32'h0;
        retire_i    = 2'b00;
        event_i     = 8'h00;
        tick(3);
        chk("rst_rdata", csr_rdata_o, 0);
        chk("rst_rhit", csr_rhit_o, 0);
        chk("rst_timer_irq", timer_irq_o, 0);
        chk("rst_ovf_irq", ovf_irq_o, 0);
        rst_i = 1'b0;

        rd(12'h7C1, d, h);  chk("mtimecmph_rst", d, 32'hFFFF_FFFF); chk("mtimecmph_hit", h, 1);
        rd(12'h320, d, h);  chk("mcountinhibit_rst", d, 0);

        // mcycle advances one per cycle
        rd(12'hB00, d1, h); chk("mcycle_hit", h, 1);
        tick(9);
        rd(12'hB00, d2, h); chk("mcycle_delta10", d2 - d1, 10);
        rd(12'hB1F, d, h);  chk("hpm31_data", d, 0); chk("hpm31_hit", h, 0);

        // minstret with dual retirement and inhibit
        retire_i = 2'b11; tick(5);
        retire_i = 2'b01; tick(3);
        retire_i = 2'b00;
        rd(12'hB02, d, h);  chk("minstret_13", d, 13);
        rd(12'hC02, d, h);  chk("instret_shadow", d, 13);
        wr(12'h320, 32'h4);
        retire_i = 2'b11; tick(4);
        retire_i = 2'b00;
        rd(12'hB02, d, h);  chk("minstret_inhibited", d, 13);
        rd(12'h320, d, h);  chk("mcountinhibit_rd", d, 4);
        wr(12'h320, 32'h0);

        // mcycle low-half wrap carries into the high half
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00, d, h);  chk("mcycle_lo_fffe", d, 32'hFFFF_FFFE);
        rd(12'hB00, d, h);  chk("mcycle_lo_ffff", d, 32'hFFFF_FFFF);
        rd(12'hB00, d, h);  chk("mcycle_lo_wrap", d, 0);
        rd(12'hB80, d, h);  chk("mcycle_hi_carry", d, 1);

        // write beats increment; same-cycle read returns pre-write value
        wr(12'hB00, 32'h1234);
        csr_waddr_i = 12'hB00; csr_wdata_i = 32'h5000;
        csr_ren_i   = 1'b1;    csr_raddr_i = 12'hB00;
        tick(1);
        d = csr_rdata_o;
        csr_waddr_i = 12'h000; csr_wdata_i = 32'h0;
        csr_ren_i   = 1'b0;    csr_raddr_i = 12'h000;
        chk("mcycle_write_wins", d, 32'h1234);
        rd(12'hB00, d, h);  chk("mcycle_raw_next", d, 32'h5000);
        wr(12'hC80, 32'h77);
        rd(12'hB80, d, h);  chk("shadow_write_ignored", d, 1);

        // HPM event selection
        wr(12'h323, 32'h2);
        pulse(8'h02, 7);
        pulse(8'h01, 4);
        rd(12'hB03, d, h);  chk("hpm3_count7", d, 7);
        rd(12'h323, d, h);  chk("hpmevent3_rd", d, 2);
        wr(12'h323, 32'hFFFF_FFE2);
        rd(12'h323, d, h);  chk("hpmevent3_mask", d, 2);
        wr(12'h323, 32'h0);
        pulse(8'h02, 3);
        rd(12'hB03, d, h);  chk("hpm3_frozen", d, 7);
        wr(12'h324, 32'h9);
        wr(12'h325, 32'h8);
        event_i = 8'hFF; tick(2); event_i = 8'h00;
        rd(12'hB04, d, h);  chk("hpm4_sel_oob", d, 0);
        rd(12'hB05, d, h);  chk("hpm5_sel_top", d, 2);
        rd(12'h327, d, h);  chk("hpmevent7_hit", h, 0);

        // timer: TIMER_DIV=4, mtimecmp=0x10 -> IRQ 65 cycles after the mtime write
        wr(12'h7C2, 32'h0);
        wr(12'h7C1, 32'h0);
        wr(12'h7C0, 32'h10);
        tick(62);
        chk("timer_irq_c64", timer_irq_o, 0);
        tick(1);
        chk("timer_irq_c65", timer_irq_o, 1);
        rd(12'hC01, d, h);  chk("time_shadow", d, 32'h10);
        wr(12'h7C0, 32'h100);
        chk("timer_irq_hold", timer_irq_o, 1);
        tick(1);
        chk("timer_irq_clear", timer_irq_o, 0);
        rd(12'h7C0, d, h);  chk("mtimecmp_rd", d, 32'h100);

        // HPM overflow
        wr(12'h323, 32'h1);
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        event_i = 8'h01; tick(1); event_i = 8'h00;
        chk("ovf_irq_lat", ovf_irq_o, 0);
        tick(1);
`ifdef BIRISCV_HPM_OVF_IRQ_EN
        chk("ovf_irq_set", ovf_irq_o, 1);
`else
        chk("ovf_irq_off", ovf_irq_o, 0);
`endif
        rd(12'hB03, d, h);  chk("hpm3_wrap_lo", d, 0);
        rd(12'hB83, d, h);  chk("hpm3_wrap_hi", d, 0);
        rd(12'h323, d, h);
`ifdef BIRISCV_HPM_OVF_IRQ_EN
        chk("hpmevent3_of", d, 32'h8000_0001);
`else
        chk("hpmevent3_noof", d, 32'h1);
`endif
        wr(12'h323, 32'h1);
        tick(1);
        chk("ovf_irq_cleared", ovf_irq_o, 0);
        rd(12'h323, d, h);  chk("hpmevent3_clr", d, 32'h1);

        // reset overrides a concurrent write
        rst_i = 1'b1; csr_waddr_i = 12'hB80; csr_wdata_i = 32'h5;
        tick(1);
        rst_i = 1'b0; csr_waddr_i = 12'h000; csr_wdata_i = 32'h0;
        rd(12'hB80, d, h);  chk("rst_beats_write", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
